hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- ID-stage hazard controller for the 5-stage MIPS pipeline. It covers the hazards that operand forwarding cannot fix: load-use, branch compared in ID, and multi-cycle multiply.
- It drives the PC, IF/ID and ID/EX write enables, the bubble and flush controls, and a saturating stall performance counter.
- A small FSM tracks multiply occupancy of EX.

Parameters:
- MUL_LAT, 4, cycles a multiply occupies EX; legal range 1..16.
- CNT_W, 16, width of StallCount.

Ports:
- Clk  input  1  clock, rising edge
- Rst  input  1  synchronous, active-high reset
- Rs_IFID  input  5  source reg Rs of instruction in IF/ID
- Rt_IFID  input  5  source reg Rt of instruction in IF/ID
- UsesRt_IFID  input  1  IF/ID instruction reads Rt as a source
- Branch_ID  input  1  IF/ID instruction is beq/bne, compared in ID
- BranchTaken_ID  input  1  ID comparator result is taken
- MemRead_IDEX  input  1  ID/EX instruction is a load
- RegWrite_IDEX  input  1  ID/EX instruction writes a register
- Rd_IDEX  input  5  ID/EX destination (final, after RegDst mux)
- MulStart_IDEX  input  1  ID/EX instruction is a multiply
- MemRead_EXMEM  input  1  EX/MEM instruction is a load
- Rd_EXMEM  input  5  EX/MEM destination
- PCWrite  output  1  PC update enable
- IFIDWrite  output  1  IF/ID register enable
- IDEXWrite  output  1  ID/EX register enable
- IDEX_Bubble  output  1  zero ID/EX control signals on next edge
- EXMEM_Bubble  output  1  zero EX/MEM control signals on next edge
- IFID_Flush  output  1  replace IF/ID with nop on next edge
- StallCount  output  CNT_W  saturating count of stall cycles

Behaviour:
- Outputs are combinational from the inputs plus the registered state. PCWrite, IFIDWrite and IDEXWrite are active-high enables.
- Reset values (while Rst=1 and in the cycle after):
  - state=RUN, cnt=0, StallCount=0.
  - PCWrite=IFIDWrite=IDEXWrite=1; all bubble and flush outputs=0.
  - While Rst=1, outputs are forced to these values regardless of inputs.
- Match terms:
  - mRs(X) = (X!=0 && X==Rs_IFID)
  - mRt(X) = (X!=0 && UsesRt_IFID && X==Rt_IFID)
  - src(X) = mRs(X) || mRt(X)
- Hazard terms:
  - LU (load-use) = MemRead_IDEX && src(Rd_IDEX)
  - BR1 = Branch_ID && RegWrite_IDEX && !MemRead_IDEX && src(Rd_IDEX)
  - BR2 = Branch_ID && MemRead_EXMEM && src(Rd_EXMEM)
  - A load followed by a dependent branch therefore stalls 2 cycles: LU, then BR2.
- FSM state RUN:
  - If MulStart_IDEX && MUL_LAT>=2: multiply stall (below).
    - Next state MUL, cnt<=MUL_LAT-2.
    - LU, BR1, BR2 and the flush are all ignored this cycle.
  - Else if LU||BR1||BR2: single stall. PCWrite=0, IFIDWrite=0, IDEXWrite=1, IDEX_Bubble=1. State stays RUN.
  - Else normal. IFID_Flush = Branch_ID && BranchTaken_ID.
  - BranchTaken_ID is never acted on in a stall cycle (operands not yet valid).
- FSM state MUL:
  - If cnt!=0: multiply stall, cnt<=cnt-1.
  - If cnt==0: no multiply stall, next state RUN, and the RUN rules for LU/BR/flush apply this cycle.
  - Total multiply stall cycles = MUL_LAT-1; MUL_LAT=1 never stalls.
- Multiply stall outputs: PCWrite=0, IFIDWrite=0, IDEXWrite=0, EXMEM_Bubble=1, IDEX_Bubble=0, IFID_Flush=0.
- Back-to-back multiply: the second MulStart_IDEX is seen in RUN the cycle after returning, which starts a new sequence.
- StallCount:
  - Increments on each clock edge where PCWrite==0 and Rst==0.
  - Saturates at 2^CNT_W-1; no wrap.
- Reset mid-MUL: abandons the sequence. The next cycle is RUN with default outputs; the pipeline flush is the CPU's responsibility.

Test Plan:
- Load-use: MemRead_IDEX=1, Rd_IDEX=8, Rs_IFID=8 for one cycle, then MemRead_IDEX=0 -> exactly 1 cycle with PCWrite=0, IFIDWrite=0, IDEX_Bubble=1; StallCount 0->1.
- Register zero and unused Rt:
  - Rd_IDEX=0=Rs_IFID with MemRead_IDEX=1 -> no stall.
  - Rd_IDEX=9=Rt_IFID with UsesRt_IFID=0 -> no stall.
- Multiply, MUL_LAT=4: MulStart_IDEX=1 held through stall -> exactly 3 cycles with PCWrite=IFIDWrite=IDEXWrite=0 and EXMEM_Bubble=1; 4th cycle enables=1, state RUN; StallCount +3. Rerun with MUL_LAT=1 -> 0 stalls.
- Branch after load:
  - Branch_ID=1, Rs_IFID=9, MemRead_IDEX=1, Rd_IDEX=9 -> stall (LU).
  - Next cycle MemRead_EXMEM=1, Rd_EXMEM=9 -> stall (BR2).
  - Third cycle BranchTaken_ID=1 -> IFID_Flush=1, PCWrite=1.
- Priority: BranchTaken_ID=1 in the same cycle as BR1 -> IFID_Flush=0, IDEX_Bubble=1. MulStart_IDEX=1 with LU true -> multiply stall outputs only (IDEX_Bubble=0).
- Reset and saturation:
  - Rst=1 during MUL with cnt=1 -> next cycle RUN, all enables=1, StallCount=0.
  - With CNT_W=2, 5 load-use stalls -> StallCount=3.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
//
// ID-stage hazard controller for a 5-stage MIPS pipeline. It handles the
// hazards that operand forwarding cannot resolve:
//   * load-use   : an ID/EX load feeds a source of the IF/ID instruction
//   * branch in ID: beq/bne compares in ID, so an operand still being
//                   produced in EX (ALU result) or MEM (load data) must
//                   be waited for
//   * multiply   : a multi-cycle multiply occupies EX for MUL_LAT cycles
//
// A two-state FSM (RUN / MUL) tracks multiply occupancy of EX. A saturating
// counter records every cycle in which the PC is held.
//
// Parameters:
//   MUL_LAT  cycles a multiply occupies EX (1..16); MUL_LAT-1 stall cycles
//   CNT_W    width of StallCount
//
// Ports:
//   Clk, Rst        clock (rising edge), synchronous active-high reset
//   Rs_IFID, Rt_IFID, UsesRt_IFID   source operands of the IF/ID instruction
//   Branch_ID, BranchTaken_ID       branch in ID and its comparator result
//   MemRead_IDEX, RegWrite_IDEX, Rd_IDEX, MulStart_IDEX  ID/EX instruction
//   MemRead_EXMEM, Rd_EXMEM         EX/MEM instruction
//   PCWrite, IFIDWrite, IDEXWrite   active-high pipeline enables
//   IDEX_Bubble, EXMEM_Bubble       zero control of the next ID/EX, EX/MEM
//   IFID_Flush                      replace IF/ID with a nop on next edge
//   StallCount                      saturating count of PC-hold cycles
// -----------------------------------------------------------------------------
module hazard_stall_unit #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [4:0]       Rs_IFID,
    input  logic [4:0]       Rt_IFID,
    input  logic             UsesRt_IFID,
    input  logic             Branch_ID,
    input  logic             BranchTaken_ID,
    input  logic             MemRead_IDEX,
    input  logic             RegWrite_IDEX,
    input  logic [4:0]       Rd_IDEX,
    input  logic             MulStart_IDEX,
    input  logic             MemRead_EXMEM,
    input  logic [4:0]       Rd_EXMEM,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXWrite,
    output logic             IDEX_Bubble,
    output logic             EXMEM_Bubble,
    output logic             IFID_Flush,
    output logic [CNT_W-1:0] StallCount
);

    // Remaining-stall counter is wide enough for MUL_LAT-2 up to 14.
    localparam int MC_W = 4;

    // Value loaded when a multiply enters EX; only meaningful for MUL_LAT>=2.
    localparam logic [MC_W-1:0] MUL_INIT =
        (MUL_LAT >= 2) ? MC_W'(MUL_LAT - 2) : '0;

    // A single-cycle multiply fits in EX like any ALU op, so it never stalls.
    localparam bit MUL_STALLS = (MUL_LAT >= 2);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_MUL = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [MC_W-1:0]   mcnt_q,  mcnt_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // -------------------------------------------------------------------------
    // Operand match terms. Register $zero is never a real dependency, and Rt
    // only counts when the IF/ID instruction actually reads it as a source.
    // -------------------------------------------------------------------------
    logic src_idex;
    logic src_exmem;

    always_comb begin
        src_idex  = 1'b0;
        src_exmem = 1'b0;

        if (Rd_IDEX != 5'd0) begin
            if (Rd_IDEX == Rs_IFID)
                src_idex = 1'b1;
            if (UsesRt_IFID && (Rd_IDEX == Rt_IFID))
                src_idex = 1'b1;
        end

        if (Rd_EXMEM != 5'd0) begin
            if (Rd_EXMEM == Rs_IFID)
                src_exmem = 1'b1;
            if (UsesRt_IFID && (Rd_EXMEM == Rt_IFID))
                src_exmem = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Hazard terms
    //   hz_lu  : load in EX feeds ID (one cycle until data reaches MEM/WB fwd)
    //   hz_br1 : ALU result in EX feeds a branch comparing in ID
    //   hz_br2 : load in MEM feeds a branch comparing in ID
    // A load followed by a dependent branch hits hz_lu then hz_br2.
    // -------------------------------------------------------------------------
    logic hz_lu;
    logic hz_br1;
    logic hz_br2;
    logic hz_any;

    always_comb begin
        hz_lu  = MemRead_IDEX && src_idex;
        hz_br1 = Branch_ID && RegWrite_IDEX && !MemRead_IDEX && src_idex;
        hz_br2 = Branch_ID && MemRead_EXMEM && src_exmem;
        hz_any = hz_lu || hz_br1 || hz_br2;
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    logic mul_stall;

    always_comb begin
        // Defaults: pipeline flows freely, state held.
        state_d      = state_q;
        mcnt_d       = mcnt_q;
        mul_stall    = 1'b0;

        PCWrite      = 1'b1;
        IFIDWrite    = 1'b1;
        IDEXWrite    = 1'b1;
        IDEX_Bubble  = 1'b0;
        EXMEM_Bubble = 1'b0;
        IFID_Flush   = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (MulStart_IDEX && MUL_STALLS) begin
                    mul_stall = 1'b1;
                    state_d   = ST_MUL;
                    mcnt_d    = MUL_INIT;
                end
            end
            ST_MUL: begin
                if (mcnt_q != '0) begin
                    mul_stall = 1'b1;
                    mcnt_d    = mcnt_q - 1'b1;
                end else begin
                    // Last EX cycle of the multiply: the held MulStart_IDEX
                    // belongs to the finishing multiply, so it is not
                    // re-examined here; only the ordinary RUN rules apply.
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                mcnt_d  = '0;
            end
        endcase

        if (mul_stall) begin
            // Freeze everything up to ID/EX and feed bubbles into MEM while
            // the multiply keeps EX busy. Load/branch hazards and the branch
            // flush are deferred until EX frees up.
            PCWrite      = 1'b0;
            IFIDWrite    = 1'b0;
            IDEXWrite    = 1'b0;
            EXMEM_Bubble = 1'b1;
        end else if (hz_any) begin
            // Hold IF and ID, push a bubble into EX. The branch comparator
            // has stale operands this cycle, so BranchTaken_ID is ignored.
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEX_Bubble = 1'b1;
        end else begin
            IFID_Flush = Branch_ID && BranchTaken_ID;
        end

        // Reset overrides everything so the pipeline sees clean enables.
        if (Rst) begin
            PCWrite      = 1'b1;
            IFIDWrite    = 1'b1;
            IDEXWrite    = 1'b1;
            IDEX_Bubble  = 1'b0;
            EXMEM_Bubble = 1'b0;
            IFID_Flush   = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Stall performance counter: counts PC-hold cycles, saturating.
    // -------------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        if (!PCWrite && (count_q != CNT_MAX))
            count_d = count_q + 1'b1;
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_RUN;
            mcnt_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
            count_q <= count_d;
        end
    end

    assign StallCount = count_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [4:0] Rs_IFID, Rt_IFID, Rd_IDEX, Rd_EXMEM;
    logic       UsesRt_IFID, Branch_ID, BranchTaken_ID;
    logic       MemRead_IDEX, RegWrite_IDEX, MulStart_IDEX, MemRead_EXMEM;

    // Main instance: MUL_LAT=4, CNT_W=16
    logic        pcw_a, ifw_a, idw_a, idb_a, exb_a, fl_a;
    logic [15:0] cnt_a;
    // Single-cycle multiply instance
    logic        pcw_b, ifw_b, idw_b, idb_b, exb_b, fl_b;
    logic [15:0] cnt_b;
    // Narrow counter instance for saturation
    logic        pcw_c, ifw_c, idw_c, idb_c, exb_c, fl_c;
    logic [1:0]  cnt_c;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    hazard_stall_unit #(.MUL_LAT(4), .CNT_W(16)) dut (
        .Clk(Clk), .Rst(Rst), .Rs_IFID(Rs_IFID), .Rt_IFID(Rt_IFID),
        .UsesRt_IFID(UsesRt_IFID), .Branch_ID(Branch_ID), .BranchTaken_ID(BranchTaken_ID),
        .MemRead_IDEX(MemRead_IDEX), .RegWrite_IDEX(RegWrite_IDEX), .Rd_IDEX(Rd_IDEX),
        .MulStart_IDEX(MulStart_IDEX), .MemRead_EXMEM(MemRead_EXMEM), .Rd_EXMEM(Rd_EXMEM),
        .PCWrite(pcw_a), .IFIDWrite(ifw_a), .IDEXWrite(idw_a), .IDEX_Bubble(idb_a),
        .EXMEM_Bubble(exb_a), .IFID_Flush(fl_a), .StallCount(cnt_a));

    hazard_stall_unit #(.MUL_LAT(1), .CNT_W(16)) dut_l1 (
        .Clk(Clk), .Rst(Rst), .Rs_IFID(Rs_IFID), .Rt_IFID(Rt_IFID),
        .UsesRt_IFID(UsesRt_IFID), .Branch_ID(Branch_ID), .BranchTaken_ID(BranchTaken_ID),
        .MemRead_IDEX(MemRead_IDEX), .RegWrite_IDEX(RegWrite_IDEX), .Rd_IDEX(Rd_IDEX),
        .MulStart_IDEX(MulStart_IDEX), .MemRead_EXMEM(MemRead_EXMEM), .Rd_EXMEM(Rd_EXMEM),
        .PCWrite(pcw_b), .IFIDWrite(ifw_b), .IDEXWrite(idw_b), .IDEX_Bubble(idb_b),
        .EXMEM_Bubble(exb_b), .IFID_Flush(fl_b), .StallCount(cnt_b));

    hazard_stall_unit #(.MUL_LAT(4), .CNT_W(2)) dut_sat (
        .Clk(Clk), .Rst(Rst), .Rs_IFID(Rs_IFID), .Rt_IFID(Rt_IFID),
        .UsesRt_IFID(UsesRt_IFID), .Branch_ID(Branch_ID), .BranchTaken_ID(BranchTaken_ID),
        .MemRead_IDEX(MemRead_IDEX), .RegWrite_IDEX(RegWrite_IDEX), .Rd_IDEX(Rd_IDEX),
        .MulStart_IDEX(MulStart_IDEX), .MemRead_EXMEM(MemRead_EXMEM), .Rd_EXMEM(Rd_EXMEM),
        .PCWrite(pcw_c), .IFIDWrite(ifw_c), .IDEXWrite(idw_c), .IDEX_Bubble(idb_c),
        .EXMEM_Bubble(exb_c), .IFID_Flush(fl_c), .StallCount(cnt_c));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge,
    // checks happen 1 further unit later.
    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle;
        Rs_IFID = 5'd0; Rt_IFID = 5'd0; UsesRt_IFID = 1'b0;
        Branch_ID = 1'b0; BranchTaken_ID = 1'b0;
        MemRead_IDEX = 1'b0; RegWrite_IDEX = 1'b0; Rd_IDEX = 5'd0;
        MulStart_IDEX = 1'b0; MemRead_EXMEM = 1'b0; Rd_EXMEM = 5'd0;
    endtask

    initial begin
        idle();
        Rst = 1'b1;
        tick(); tick();

        // Reset forces outputs even with a live load-use hazard present
        MemRead_IDEX = 1'b1; Rd_IDEX = 5'd8; Rs_IFID = 5'd8;
        #1;
        chk("rst_pcwrite", 32'(pcw_a), 1);
        chk("rst_bubble", 32'(idb_a), 0);
        tick();
        idle();
        Rst = 1'b0;
        #1;
        chk("rst_count", 32'(cnt_a), 0);
        chk("rst_idexwrite", 32'(idw_a), 1);

        // Load-use: one stall cycle
        MemRead_IDEX = 1'b1; Rd_IDEX = 5'd8; Rs_IFID = 5'd8;
        #1;
        chk("lu_pcwrite", 32'(pcw_a), 0);
        chk("lu_ifidwrite", 32'(ifw_a), 0);
        chk("lu_idexwrite", 32'(idw_a), 1);
        chk("lu_bubble", 32'(idb_a), 1);
        chk("lu_exmem_bubble", 32'(exb_a), 0);
        tick();
        MemRead_IDEX = 1'b0;
        #1;
        chk("lu_after_pcwrite", 32'(pcw_a), 1);
        chk("lu_after_bubble", 32'(idb_a), 0);
        chk("lu_count", 32'(cnt_a), 1);

        // $zero and unused Rt never match
        MemRead_IDEX = 1'b1; Rd_IDEX = 5'd0; Rs_IFID = 5'd0;
        #1;
        chk("zero_reg_pcwrite", 32'(pcw_a), 1);
        Rd_IDEX = 5'd9; Rt_IFID = 5'd9; Rs_IFID = 5'd3; UsesRt_IFID = 1'b0;
        #1;
        chk("rt_unused_pcwrite", 32'(pcw_a), 1);
        UsesRt_IFID = 1'b1;
        #1;
        chk("rt_used_pcwrite", 32'(pcw_a), 0);
        tick();
        idle();
        #1;
        chk("count_after_rt", 32'(cnt_a), 2);

        // Multiply, MUL_LAT=4: three stall cycles, MulStart held throughout
        MulStart_IDEX = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("mul%0d_pcwrite", i), 32'(pcw_a), 0);
            chk($sformatf("mul%0d_idexwrite", i), 32'(idw_a), 0);
            chk($sformatf("mul%0d_exmem_bubble", i), 32'(exb_a), 1);
            chk($sformatf("mul%0d_idex_bubble", i), 32'(idb_a), 0);
            chk($sformatf("mul%0d_lat1_pcwrite", i), 32'(pcw_b), 1);
            tick();
        end
        #1;
        chk("mul_end_pcwrite", 32'(pcw_a), 1);
        chk("mul_end_idexwrite", 32'(idw_a), 1);
        chk("mul_end_exmem_bubble", 32'(exb_a), 0);
        chk("mul_end_lat1_pcwrite", 32'(pcw_b), 1);
        tick();
        idle();
        #1;
        chk("mul_count", 32'(cnt_a), 5);
        chk("mul_lat1_count", 32'(cnt_b), 2);

        // Branch after load: LU stall, BR2 stall, then resolve taken
        Branch_ID = 1'b1; BranchTaken_ID = 1'b1; Rs_IFID = 5'd9;
        MemRead_IDEX = 1'b1; RegWrite_IDEX = 1'b1; Rd_IDEX = 5'd9;
        #1;
        chk("br_lu_pcwrite", 32'(pcw_a), 0);
        chk("br_lu_flush", 32'(fl_a), 0);
        chk("br_lu_bubble", 32'(idb_a), 1);
        tick();
        MemRead_IDEX = 1'b0; RegWrite_IDEX = 1'b0; Rd_IDEX = 5'd0;
        MemRead_EXMEM = 1'b1; Rd_EXMEM = 5'd9;
        #1;
        chk("br2_pcwrite", 32'(pcw_a), 0);
        chk("br2_flush", 32'(fl_a), 0);
        tick();
        MemRead_EXMEM = 1'b0; Rd_EXMEM = 5'd0;
        #1;
        chk("br_taken_pcwrite", 32'(pcw_a), 1);
        chk("br_taken_flush", 32'(fl_a), 1);
        tick();
        idle();
        #1;
        chk("br_count", 32'(cnt_a), 7);

        // BR1 outranks a taken branch
        Branch_ID = 1'b1; BranchTaken_ID = 1'b1; RegWrite_IDEX = 1'b1;
        Rd_IDEX = 5'd5; Rs_IFID = 5'd5;
        #1;
        chk("br1_flush", 32'(fl_a), 0);
        chk("br1_bubble", 32'(idb_a), 1);
        chk("br1_pcwrite", 32'(pcw_a), 0);
        tick();
        idle();

        // Multiply outranks load-use
        MulStart_IDEX = 1'b1; MemRead_IDEX = 1'b1; Rd_IDEX = 5'd7; Rs_IFID = 5'd7;
        #1;
        chk("mul_lu_idex_bubble", 32'(idb_a), 0);
        chk("mul_lu_exmem_bubble", 32'(exb_a), 1);
        chk("mul_lu_idexwrite", 32'(idw_a), 0);
        chk("mul_lu_lat1_bubble", 32'(idb_b), 1);
        tick();             // MUL, cnt=2
        tick();             // MUL, cnt=1
        #1;
        chk("mul_mid_pcwrite", 32'(pcw_a), 0);

        // Reset while in MUL with cnt=1
        idle();
        Rst = 1'b1;
        #1;
        chk("rst_mul_pcwrite", 32'(pcw_a), 1);
        chk("rst_mul_exmem_bubble", 32'(exb_a), 0);
        tick();
        Rst = 1'b0;
        #1;
        chk("post_rst_pcwrite", 32'(pcw_a), 1);
        chk("post_rst_idexwrite", 32'(idw_a), 1);
        chk("post_rst_exmem_bubble", 32'(exb_a), 0);
        chk("post_rst_count", 32'(cnt_a), 0);
        // Back in RUN: a load-use hazard gets the single-stall response
        MemRead_IDEX = 1'b1; Rd_IDEX = 5'd4; Rs_IFID = 5'd4;
        #1;
        chk("post_rst_lu_bubble", 32'(idb_a), 1);
        chk("post_rst_lu_idexwrite", 32'(idw_a), 1);

        // Five consecutive load-use stalls: narrow counter saturates at 3
        for (int i = 0; i < 5; i++) tick();
        idle();
        #1;
        chk("sat_count_w2", 32'(cnt_c), 3);
        chk("sat_count_w16", 32'(cnt_a), 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #20000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
